// File: rtl/fifo_rd_arb.sv
// Round-robin burst reader for NPORT async-FIFO read ports into one ready/valid stream.
// `define FIFO_RD_ARB_BURST_EN for bursts of up to BURST_LEN reads per grant; without it each grant reads one word.
module fifo_rd_arb #(
  parameter int WIDTH     = 5,
  parameter int NPORT     = 4,
  parameter int BURST_LEN = 4,
  localparam int SRC_W    = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic                   r_clk,
  input  logic                   rst,
  input  logic [NPORT-1:0]       fifo_empty,
  input  logic [NPORT-1:0]       fifo_almost_empty,
  input  logic [NPORT*WIDTH-1:0] fifo_dat,
  output logic [NPORT-1:0]       fifo_r_en,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_dat,
  output logic [SRC_W-1:0]       m_src,
  output logic                   busy
);

`ifdef FIFO_RD_ARB_BURST_EN
  localparam int BL_EFF = BURST_LEN;
`else
  localparam int BL_EFF = 1;
`endif
  localparam int BC_W = $clog2(BURST_LEN + 1);
  localparam logic [BC_W-1:0] BL_LIM = BC_W'(BL_EFF);

  // state | meaning:  S_IDLE | pick next non-empty port from r_p;  S_BURST | read granted port r_g
  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t           r_state;
  logic [SRC_W-1:0] r_g;
  logic [SRC_W-1:0] r_p;
  logic [BC_W-1:0]  r_bcnt;
  logic             r_pend;
  logic [SRC_W-1:0] r_pend_src;
  logic [WIDTH-1:0] r_buf_dat [2];
  logic [SRC_W-1:0] r_buf_src [2];
  logic             r_head;
  logic             r_tail;
  logic [1:0]       r_cnt;

  logic             w_found;
  logic [SRC_W-1:0] w_sel;
  logic             w_pop;
  logic [2:0]       w_occ;
  logic             w_rd;
  logic [BC_W-1:0]  w_bcnt_nxt;
  logic [SRC_W-1:0] w_p_nxt;

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NPORT; k++) begin
      if (!w_found && !fifo_empty[(int'(r_p) + k) % NPORT]) begin
        w_found = 1'b1;
        w_sel   = SRC_W'((int'(r_p) + k) % NPORT);
      end
    end
  end

  // A read is only allowed if its word is guaranteed a buffer slot two cycles later.
  assign w_pop      = (r_cnt != 2'd0) && m_ready;
  assign w_occ      = {1'b0, r_cnt} - {2'b00, w_pop} + {2'b00, r_pend};
  assign w_rd       = (r_state == S_BURST) && !fifo_empty[r_g] && (w_occ < 3'd2);
  assign w_bcnt_nxt = r_bcnt + 1'b1;
  assign w_p_nxt    = (r_g == SRC_W'(NPORT - 1)) ? '0 : r_g + 1'b1;

  assign fifo_r_en = w_rd ? (NPORT'(1) << r_g) : '0;
  assign m_valid   = (r_cnt != 2'd0);
  assign m_dat     = r_buf_dat[r_head];
  assign m_src     = r_buf_src[r_head];
  assign busy      = (r_state == S_BURST) || r_pend || (r_cnt != 2'd0);

  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_g     <= '0;
      r_p     <= '0;
      r_bcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_g     <= w_sel;
            r_bcnt  <= '0;
            r_state <= S_BURST;
          end
        end
        S_BURST: begin
          if (fifo_empty[r_g]) begin
            r_state <= S_IDLE;
            r_p     <= w_p_nxt;
            r_bcnt  <= '0;
          end else if (w_rd) begin
            r_bcnt <= w_bcnt_nxt;
            if ((w_bcnt_nxt == BL_LIM) || fifo_almost_empty[r_g]) begin
              r_state <= S_IDLE;
              r_p     <= w_p_nxt;
              r_bcnt  <= '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      r_pend     <= 1'b0;
      r_pend_src <= '0;
      r_head     <= 1'b0;
      r_tail     <= 1'b0;
      r_cnt      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_buf_dat[i] <= '0;
        r_buf_src[i] <= '0;
      end
    end else begin
      r_pend     <= w_rd;
      r_pend_src <= r_g;
      if (r_pend) begin
        r_buf_dat[r_tail] <= fifo_dat[int'(r_pend_src) * WIDTH +: WIDTH];
        r_buf_src[r_tail] <= r_pend_src;
        r_tail            <= ~r_tail;
      end
      if (w_pop) r_head <= ~r_head;
      r_cnt <= r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
    end
  end

endmodule

// File: doc/fifo_rd_arb.md
FIFO_RD_ARB -- requirements
Module: fifo_rd_arb

Interface
REQ-001 Parameter WIDTH, default 5, data word width in bits.
REQ-002 Parameter NPORT, default 4, number of async FIFO read ports arbitrated (2..8).
REQ-003 Parameter BURST_LEN, default 4, maximum words read per grant (1..16).
REQ-004 Derived constant SRC_W = max(1, ceil(log2 NPORT)).
REQ-005 r_clk  input  1  read-domain clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 fifo_empty  input  NPORT  per-port r_empty from each FIFO.
REQ-008 fifo_almost_empty  input  NPORT  per-port r_almost_empty; high when the FIFO holds at most one word.
REQ-009 fifo_dat  input  NPORT*WIDTH  per-port o_dat; port i occupies bits [i*WIDTH +: WIDTH].
REQ-010 fifo_r_en  output  NPORT  per-port read enable; at most one bit high per cycle.
REQ-011 m_valid  output  1  output word valid.
REQ-012 m_ready  input  1  downstream accepts the word; transfer when m_valid and m_ready are both high.
REQ-013 m_dat  output  WIDTH  output word.
REQ-014 m_src  output  SRC_W  index of the port m_dat came from.
REQ-015 busy  output  1  high while state is BURST or a word is in flight or buffered.

Function
REQ-016 FIFO read timing is fixed: fifo_dat[i] holds the word read by fifo_r_en[i] during the cycle after the enable.
REQ-017 States: IDLE and BURST; grant register g (SRC_W bits); round-robin pointer p.
REQ-018 IDLE: if any fifo_empty bit is low, g takes the first non-empty port searching p, p+1, ..., wrapping modulo NPORT; next state is BURST; otherwise remain IDLE.
REQ-019 BURST: fifo_r_en[g] is high only when fifo_empty[g] is low and (buffer occupancy − pop this cycle + in-flight reads) < 2.
REQ-020 The burst ends, with next state IDLE and p = (g+1) mod NPORT, when any of these holds:
- BURST_LEN reads have been issued;
- fifo_empty[g] is sampled high;
- a read is issued while fifo_almost_empty[g] is high.
REQ-021 The read that hits the BURST_LEN limit or the almost-empty condition counts toward the burst and completes normally.
REQ-022 An internal 2-entry output buffer captures fifo_dat[g] and g at the end of the cycle after each read.
REQ-023 m_valid asserts in the second cycle after the enabling fifo_r_en cycle (latency 2).
REQ-024 m_dat and m_src are taken from the buffer head and held stable while m_valid is high and m_ready is low.
REQ-025 The buffer never overflows under any m_ready pattern.
REQ-026 With m_ready held high and one port holding many words, throughput is 1 word per cycle within a burst.
REQ-027 Each burst end costs exactly one IDLE cycle.
REQ-028 Words are delivered in read order; no word is duplicated or dropped.

Reset
REQ-029 On rst: state IDLE, p=0, g=0, fifo_r_en=0, m_valid=0, m_dat=0, m_src=0, busy=0, buffer empty, burst counter 0.
REQ-030 rst asserted mid-burst discards in-flight and buffered words; no fifo_r_en is issued until the first rising edge after rst deasserts.

Configuration
REQ-031 Macro FIFO_RD_ARB_BURST_EN: when defined, bursts follow BURST_LEN as specified above.
REQ-032 When FIFO_RD_ARB_BURST_EN is undefined, BURST_LEN is ignored and each grant issues exactly one read, giving word-interleaved round-robin.
REQ-033 All other behaviour is identical with or without FIFO_RD_ARB_BURST_EN.

Verification
REQ-034 Reset check: with rst high, all outputs are 0; after release with all fifo_empty=1, state stays IDLE and busy=0 for 20 cycles.
REQ-035 Single port: port 2 holds 10 words (7..16), m_ready=1, BURST_EN defined -> words arrive in 3 bursts of 4,4,2 with a one-cycle gap between bursts; m_src=2 throughout; first m_valid appears 3 cycles after fifo_empty[2] falls.
REQ-036 Fairness: all 4 ports hold 8 words each, m_ready=1 -> m_src sequence 0,0,0,0,1,1,1,1,2,...; with the macro undefined the sequence is 0,1,2,3,0,1,...
REQ-037 Backpressure: m_ready toggles 1-of-3 cycles -> no loss or duplication, at most 2 words outstanding, m_dat stable while stalled.
REQ-038 Near-empty: port 1 holds 1 word (fifo_almost_empty=1) -> exactly one read, burst ends, p advances to 2, and fifo_r_en[1] is never high while fifo_empty[1]=1.
REQ-039 Mid-operation reset: rst pulsed in the cycle after a read -> m_valid=0 immediately, the word is not delivered, and arbitration restarts from port 0.
